prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
- Instruction prefetch stage between the fetch control path and the instruction decoder.
- Fetches 32-bit instructions as two 16-bit halfwords over the shared 16-bit memory bus and buffers them in a small FIFO.
- Presents the oldest instruction to the decoder with a valid/ready handshake.
- Flushes and redirects on control-flow change.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16)
- RESET_ADDR, 16'h0000, first fetch halfword address after reset (even)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cs_pfq  in  1  fetch enable; low = stop after the current instruction
- flush  in  1  discard queue and in-flight fetch, redirect
- flush_addr  in  16  new fetch halfword address; bit0 ignored (forced 0)
- mem_req  out  1  bus read request
- mem_addr  out  16  halfword address of the current request
- mem_data  in  16  read data, valid when mem_ready=1
- mem_ready  in  1  bus completes the current read this cycle
- ir  out  32  head instruction {hi halfword, lo halfword}; 0 when empty
- ir_valid  out  1  queue non-empty
- dec_ready  in  1  decoder accepts ir this cycle
- count  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, async): mem_req=0, mem_addr=RESET_ADDR, pc=RESET_ADDR, ir=0, ir_valid=0, count=0, FSM=IDLE, FIFO pointers=0.
- FSM states: IDLE, REQ_LO, REQ_HI.
- IDLE: if cs_pfq=1 and (count<DEPTH or pop this cycle), go to REQ_LO next cycle with mem_req=1 and mem_addr=pc.
- REQ_LO:
  - mem_req=1 and mem_addr held stable until mem_ready.
  - On mem_ready: lo_buf<=mem_data, mem_addr<=pc+1, go to REQ_HI.
- REQ_HI:
  - On mem_ready: push {mem_data, lo_buf}, pc<=pc+2.
  - Then go to REQ_LO (mem_addr=new pc) if cs_pfq=1 and space remains after this cycle's push/pop; otherwise go to IDLE with mem_req=0.
- Space is checked only before REQ_LO. Only the FSM pushes, so a push never overflows.
- Pop occurs when ir_valid and dec_ready are both 1. The head advances on the next edge.
- Latency:
  - Minimum 2 cycles from REQ_LO entry to push (both mem_ready=1 immediately).
  - ir_valid rises on the cycle after the push edge.
  - No bypass.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop with dec_ready=1 while empty: no effect.
- Address arithmetic is modulo 2^16: pc=16'hFFFE, after push pc=16'h0000; the hi fetch of 16'hFFFE uses address 16'hFFFF.
- cs_pfq falling mid-instruction: the current two-halfword fetch completes and is pushed, then IDLE.
- flush (synchronous, highest priority):
  - Next edge: count=0, pointers=0, ir_valid=0, pc=mem_addr={flush_addr[15:1],1'b0}, lo_buf discarded, FSM=IDLE, mem_req=0.
  - mem_ready and dec_ready in the flush cycle are ignored.
  - Refetch begins the following cycle if cs_pfq=1.
- Reset asserted mid-operation: immediate return to reset values. The in-flight request is abandoned; the bus must tolerate mem_req dropping.

Optional Feature:
- PFQ_PERF_EN defined:
  - Adds output perf_fetch_cnt[15:0], counting pushed instructions, saturating at 16'hFFFF.
  - Cleared by reset, not by flush.
  - Adds output perf_stall_cnt[15:0], counting cycles with ir_valid=0 and cs_pfq=1, also saturating.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pfq_pkg: FSM state enum (IDLE, REQ_LO, REQ_HI), INSTR_W=32, HALF_W=16, default RESET_ADDR.
- Sub-module pfq_fifo: DEPTH x 32 storage with wr_en, rd_en, flush, count and head data.
- prefetch_queue holds the FSM, pc, lo_buf and perf counters.

Test Plan:
- Reset: hold reset=0 with random inputs -> mem_req=0, mem_addr=16'h0000, ir_valid=0, count=0, ir=0.
- Fill: cs_pfq=1, dec_ready=0, mem_ready=1, mem_data=addr -> four pushes, then mem_req=0 and count=4; head ir=32'h0001_0000, next 32'h0003_0002.
- Stream: dec_ready=1, mem_ready=1 -> one instruction every 2 cycles; count stays at most 1; ir sequence increments by 32'h0002_0002.
- Bus stall: mem_ready=0 for 5 cycles in REQ_HI -> mem_addr stable at pc+1, no push; push occurs on the first mem_ready=1 cycle.
- Flush: flush in REQ_HI with mem_ready=1, flush_addr=16'h1235 -> no push, count=0, next request mem_addr=16'h1234.
- Wrap and simultaneous push/pop: pc=16'hFFFE with count=2 and dec_ready=1 -> hi fetch at 16'hFFFF; push and pop in the same cycle leave count=2; next fetch at 16'h0000.

Source files
------------

// File: rtl/pfq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package pfq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_LO = 2'd1,
    REQ_HI = 2'd2
  } pfq_state_t;

  localparam int INSTR_W = 32;
  localparam int HALF_W  = 16;

  localparam logic [HALF_W-1:0] PFQ_RESET_ADDR = 16'h0000;

endpackage

// File: rtl/pfq_fifo.sv
// DEPTH x 32-bit instruction FIFO with synchronous flush; head reads as 0 when empty.
module pfq_fifo
  import pfq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [CW-1:0]      count,
  output logic [INSTR_W-1:0] head
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               do_rd;

  // A read request against an empty queue is silently dropped.
  assign do_rd = rd_en && (count != '0);
  assign head  = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch: two-halfword bus fetch FSM feeding a FIFO toward the decoder.
// Optional PFQ_PERF_EN adds saturating fetch/stall performance counters.
module prefetch_queue
  import pfq_pkg::*;
#(
  parameter  int                DEPTH      = 4,
  parameter  logic [HALF_W-1:0] RESET_ADDR = PFQ_RESET_ADDR,
  localparam int                CW         = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs_pfq,
  input  logic               flush,
  input  logic [HALF_W-1:0]  flush_addr,
  output logic               mem_req,
  output logic [HALF_W-1:0]  mem_addr,
  input  logic [HALF_W-1:0]  mem_data,
  input  logic               mem_ready,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               dec_ready,
  output logic [CW-1:0]      count
`ifdef PFQ_PERF_EN
  ,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_stall_cnt
`endif
);

  pfq_state_t        state, state_nxt;
  logic [HALF_W-1:0] pc, pc_nxt, addr_nxt, lo_buf, lo_nxt;
  logic              pop, push, space_after;

  assign ir_valid = (count != '0);
  assign pop      = ir_valid && dec_ready;
  assign push     = (state == REQ_HI) && mem_ready && !flush;
  assign mem_req  = (state != IDLE);

  // Occupancy after this cycle's push and pop; decides whether another fetch may start.
  assign space_after = (int'(count) + 1 - int'(pop)) < DEPTH;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = mem_addr;
    lo_nxt    = lo_buf;
    if (flush) begin
      state_nxt = IDLE;
      pc_nxt    = {flush_addr[HALF_W-1:1], 1'b0};
      addr_nxt  = {flush_addr[HALF_W-1:1], 1'b0};
      lo_nxt    = '0;
    end else begin
      case (state)
        IDLE: if (cs_pfq && (int'(count) < DEPTH || pop)) begin
          state_nxt = REQ_LO;
          addr_nxt  = pc;
        end
        REQ_LO: if (mem_ready) begin
          lo_nxt    = mem_data;
          addr_nxt  = pc + 16'd1;
          state_nxt = REQ_HI;
        end
        REQ_HI: if (mem_ready) begin
          pc_nxt    = pc + 16'd2;
          addr_nxt  = pc + 16'd2;
          state_nxt = (cs_pfq && space_after) ? REQ_LO : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_ADDR;
      mem_addr <= RESET_ADDR;
      lo_buf   <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      mem_addr <= addr_nxt;
      lo_buf   <= lo_nxt;
    end
  end

  pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (push),
    .wr_data ({mem_data, lo_buf}),
    .rd_en   (pop && !flush),
    .count   (count),
    .head    (ir)
  );

`ifdef PFQ_PERF_EN
  // Counters survive flush so they span whole program runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != 16'hFFFF) perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (!ir_valid && cs_pfq && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomized bench for prefetch_queue: bus-handshake scoreboard with a queue-based model.
module tb_prefetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_pfq, flush, mem_ready, dec_ready;
  logic [15:0] flush_addr, mem_addr, mem_data, key;
  logic        mem_req, ir_valid;
  logic [31:0] ir;
  logic [2:0]  count;
`ifdef PFQ_PERF_EN
  logic [15:0] perf_fetch_cnt, perf_stall_cnt;
  int          m_fetch, m_stall;
`endif

  always #5 clk = ~clk;

  assign mem_data = mem_addr ^ key;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs_pfq     (cs_pfq),
    .flush      (flush),
    .flush_addr (flush_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .dec_ready  (dec_ready),
    .count      (count)
`ifdef PFQ_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: instructions in queue order plus the next halfword address the bus should see.
  logic [31:0] mq[$];
  logic [15:0] exp_addr, lo_exp;
  bit          hi_phase;
  int          pushes;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_addr = 16'h0000;
    lo_exp   = 16'h0000;
    hi_phase = 1'b0;
    pushes   = 0;
`ifdef PFQ_PERF_EN
    m_fetch = 0;
    m_stall = 0;
`endif
  endtask

  task automatic cyc(input bit cs, input bit fl, input logic [15:0] fa, input bit mr, input bit dr);
    bit req_pre;
    cs_pfq = cs; flush = fl; flush_addr = fa; mem_ready = mr; dec_ready = dr;
    req_pre = mem_req;
`ifdef PFQ_PERF_EN
    if (mq.size() == 0 && cs && m_stall < 65535) m_stall++;
`endif
    if (fl) begin
      mq.delete();
      exp_addr = {fa[15:1], 1'b0};
      hi_phase = 1'b0;
    end else begin
      if (mem_req && !hi_phase) chk("space", 32'(mq.size() < DEPTH), 32'd1);
      if (dr && mq.size() > 0) mq.delete(0);
      if (mem_req && mr) begin
        chk("addr", 32'(mem_addr), 32'(exp_addr));
        if (!hi_phase) lo_exp = exp_addr ^ key;
        else begin
          mq.push_back({exp_addr ^ key, lo_exp});
          pushes++;
`ifdef PFQ_PERF_EN
          if (m_fetch < 65535) m_fetch++;
`endif
        end
        exp_addr = exp_addr + 16'd1;
        hi_phase = !hi_phase;
      end
    end
    @(posedge clk); #1;
    chk("ir_valid", 32'(ir_valid), 32'(mq.size() > 0));
    chk("count", 32'(count), 32'(mq.size()));
    chk("ir", ir, (mq.size() > 0) ? mq[0] : 32'h0);
    if (fl) begin
      chk("flush_req", 32'(mem_req), 32'd0);
      chk("flush_addr", 32'(mem_addr), 32'(exp_addr));
    end else if (!cs && !req_pre) chk("stop_req", 32'(mem_req), 32'd0);
`ifdef PFQ_PERF_EN
    chk("perf_fetch", 32'(perf_fetch_cnt), 32'(m_fetch));
    chk("perf_stall", 32'(perf_stall_cnt), 32'(m_stall));
`endif
  endtask

  task automatic to_hi_phase();
    int n = 0;
    while (!(hi_phase && mem_req) && n < 12) begin
      cyc(1, 0, 16'h0, 1, 1);
      n++;
    end
    chk("reach_hi", 32'(hi_phase && mem_req), 32'd1);
  endtask

  initial begin
    int p0, sz, n;
    logic [15:0] stall_addr;
    reset = 1'b0; key = 16'h0;
    cs_pfq = 1'b0; flush = 1'b0; flush_addr = 16'h0; mem_ready = 1'b0; dec_ready = 1'b0;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      cs_pfq = 1'($urandom); flush = 1'($urandom); flush_addr = 16'($urandom);
      mem_ready = 1'($urandom); dec_ready = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_valid", 32'(ir_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ir", ir, 32'h0);
    end
    reset = 1'b1;

    // Fill until full
    for (int i = 0; i < 12; i++) cyc(1, 0, 16'h0, 1, 0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_req", 32'(mem_req), 32'd0);
    chk("fill_head", ir, 32'h0001_0000);
    cyc(1, 0, 16'h0, 0, 1);
    chk("fill_next", ir, 32'h0003_0002);

    // Stream: one instruction every two cycles
    cyc(1, 1, 16'h0100, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 16'h0, 1, 1);
    p0 = pushes;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 16'h0, 1, 1);
      chk("stream_cnt", 32'(count <= 3'd1), 32'd1);
    end
    chk("stream_rate", 32'(pushes - p0), 32'd10);

    // Bus stall in the high-half fetch
    to_hi_phase();
    stall_addr = mem_addr;
    chk("stall_addr", 32'(stall_addr), 32'(exp_addr));
    sz = mq.size();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 16'h0, 0, 0);
      chk("stall_hold", 32'(mem_addr), 32'(stall_addr));
      chk("stall_nopush", 32'(count), 32'(sz));
    end
    cyc(1, 0, 16'h0, 1, 0);
    chk("stall_push", 32'(count), 32'(sz + 1));

    // Flush during high-half completion
    to_hi_phase();
    cyc(1, 1, 16'h1235, 1, 1);
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_a", 32'(mem_addr), 32'h1234);
    cyc(1, 0, 16'h0, 0, 0);
    chk("refetch_req", 32'(mem_req), 32'd1);
    chk("refetch_addr", 32'(mem_addr), 32'h1234);

    // Address wrap with simultaneous push/pop
    cyc(1, 1, 16'hFFFA, 0, 0);
    n = 0;
    while (mq.size() < 2 && n < 20) begin cyc(1, 0, 16'h0, 1, 0); n++; end
    chk("wrap_fill", 32'(mq.size()), 32'd2);
    chk("wrap_lo", 32'(mem_addr), 32'hFFFE);
    cyc(1, 0, 16'h0, 1, 0);
    chk("wrap_hi", 32'(mem_addr), 32'hFFFF);
    cyc(1, 0, 16'h0, 1, 1);
    chk("wrap_cnt", 32'(count), 32'd2);
    chk("wrap_next", 32'(mem_addr), 32'h0000);
    chk("wrap_ir", ir, 32'hFFFD_FFFC);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      key = 16'($urandom);
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), 16'($urandom),
          ($urandom_range(0, 2) != 0), 1'($urandom));
    end

    // Asynchronous reset mid-operation
    key = 16'h0;
    while (!mem_req && n < 40) begin cyc(1, 0, 16'h0, 0, 0); n++; end
    #3 reset = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 30; i++) cyc(1, 0, 16'h0, 1, 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
